// File: rtl/lsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsm_pkg
// Brief    : Shared definitions for the LDM/STM/PUSH/POP sequencer: opcode
//            patterns, FSM state encoding, architectural register indices
//            and small decode helpers.
// Revision : 1.0 - initial release
// ============================================================================
package lsm_pkg;

  // Instruction bits 15:9. STM/LDM carry Rn[2:1] in the two low bits.
  localparam logic [6:0] OP_STM  = 7'b1100_0??;
  localparam logic [6:0] OP_LDM  = 7'b1100_1??;
  localparam logic [6:0] OP_PUSH = 7'b1011_010;
  localparam logic [6:0] OP_POP  = 7'b1011_110;

  // Architectural register indices
  localparam logic [3:0] SP = 4'd13;
  localparam logic [3:0] LR = 4'd14;
  localparam logic [3:0] PC = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    LWB  = 2'd2,
    FIN  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_STM  = 3'd1,
    CLS_LDM  = 3'd2,
    CLS_PUSH = 3'd3,
    CLS_POP  = 3'd4
  } op_cls_t;

  // Classify the latched instruction bits into one of the four operations.
  function automatic op_cls_t decode_op(input logic [6:0] op);
    op_cls_t cls;
    casez (op)
      OP_STM:  cls = CLS_STM;
      OP_LDM:  cls = CLS_LDM;
      OP_PUSH: cls = CLS_PUSH;
      OP_POP:  cls = CLS_POP;
      default: cls = CLS_NONE;
    endcase
    return cls;
  endfunction

  // List bit 8 is LR on the store side (PUSH) and PC on the load side (POP).
  function automatic logic [3:0] map_reg(input logic [3:0] k, input logic is_load);
    logic [3:0] r;
    if (k == 4'd8) r = is_load ? PC : LR;
    else           r = k;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_list_pe.sv
`default_nettype none
// ============================================================================
// Module   : reg_list_pe
// Brief    : Lowest-set-bit priority encoder over the register list.
//            o_valid is low when the list is empty.
// Revision : 1.0 - initial release
// ============================================================================
module reg_list_pe #(
  parameter int NREGS = 9,
  parameter int IDXW  = $clog2(NREGS)
) (
  input  logic [NREGS-1:0] i_vec,
  output logic [IDXW-1:0]  o_idx,
  output logic             o_valid
);

  // Scan high to low so the lowest set bit is the last one to assign.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int j = NREGS - 1; j >= 0; j--) begin
      if (i_vec[j]) begin
        o_idx   = IDXW'(j);
        o_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ldm_stm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ldm_stm_sequencer
// Brief    : MEM-stage initiator for STM/LDM/PUSH/POP. Latches the register
//            list and base, issues one word access per cycle in ascending
//            address order, returns load data one cycle after each address
//            (data_mem reads are registered), and reports the updated base.
//            Optional macro POP_PC_BRANCH_EN: a POP into PC raises pc_load /
//            pc_target instead of writing r15 through the writeback port.
// Revision : 1.0 - initial release
// ============================================================================
module ldm_stm_sequencer
  import lsm_pkg::*;
#(
  parameter int ADDR_STEP = 4,
  parameter int NREGS     = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [6:0]       opCode,
  input  logic [2:0]       base_reg,
  input  logic [NREGS-1:0] reg_list,
  input  logic [31:0]      base_addr,
  output logic [3:0]       rf_read_addr,
  input  logic [31:0]      rf_read_data,
  output logic             mem_write_en,
  output logic [6:0]       mem_opCode,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_data_in,
  input  logic [31:0]      mem_data_out,
  output logic             wb_en,
  output logic [3:0]       wb_reg,
  output logic [31:0]      wb_data,
  output logic             base_wb_en,
  output logic [3:0]       base_wb_reg,
  output logic [31:0]      base_wb_data,
  output logic             busy,
`ifdef POP_PC_BRANCH_EN
  output logic             pc_load,
  output logic [31:0]      pc_target,
`endif
  output logic             done
);

  localparam int IDXW = $clog2(NREGS);

  state_t           r_state;
  state_t           w_next;
  op_cls_t          r_cls;
  logic [6:0]       r_opcode;
  logic [NREGS-1:0] r_list;
  logic [31:0]      r_addr;
  logic [31:0]      r_base_new;
  logic [3:0]       r_base_reg;
  logic             r_base_ok;
  logic             r_wb_pend;
  logic [3:0]       r_wb_reg;
`ifdef POP_PC_BRANCH_EN
  logic             r_wb_pc;
`endif

  op_cls_t          w_cls;
  logic [NREGS-1:0] w_list_in;
  logic [31:0]      w_cnt;
  logic [31:0]      w_span;
  logic [IDXW-1:0]  w_idx;
  logic             w_valid;
  logic [3:0]       w_k;
  logic [NREGS-1:0] w_rem;
  logic             w_last;
  logic             w_is_load;

  assign w_cls     = decode_op(opCode);
  assign w_list_in = (w_cls == CLS_NONE) ? '0 : reg_list;
  assign w_span    = w_cnt * 32'(ADDR_STEP);
  assign w_k       = 4'(w_idx);
  assign w_rem     = r_list & ~({{(NREGS-1){1'b0}}, 1'b1} << w_idx);
  assign w_last    = (w_rem == '0);
  assign w_is_load = (r_cls == CLS_LDM) || (r_cls == CLS_POP);
  assign mem_opCode = r_opcode;

  reg_list_pe #(
    .NREGS (NREGS),
    .IDXW  (IDXW)
  ) u_pe (
    .i_vec   (r_list),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  // Number of registers in the incoming list, used for the base adjustment.
  always_comb begin
    w_cnt = '0;
    for (int j = 0; j < NREGS; j++) begin
      w_cnt = w_cnt + 32'(w_list_in[j]);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Latch the operation at start, then walk the list and the address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cls      <= CLS_NONE;
      r_opcode   <= '0;
      r_list     <= '0;
      r_addr     <= '0;
      r_base_new <= '0;
      r_base_reg <= '0;
      r_base_ok  <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_cls      <= w_cls;
      r_opcode   <= opCode;
      r_list     <= w_list_in;
      // PUSH is full-descending but still transfers in ascending order.
      r_addr     <= (w_cls == CLS_PUSH) ? base_addr - w_span : base_addr;
      r_base_new <= (w_cls == CLS_PUSH) ? base_addr - w_span : base_addr + w_span;
      r_base_reg <= (w_cls == CLS_PUSH || w_cls == CLS_POP) ? SP : {1'b0, base_reg};
      // A loaded Rn wins over the write-back of the base.
      r_base_ok  <= (w_cls != CLS_NONE) && !(w_cls == CLS_LDM && reg_list[base_reg]);
    end else if (r_state == XFER && w_valid) begin
      r_list <= w_rem;
      r_addr <= r_addr + 32'(ADDR_STEP);
    end
  end

  // Load writeback trails its address by one cycle to match data_mem's read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_pend <= 1'b0;
      r_wb_reg  <= '0;
`ifdef POP_PC_BRANCH_EN
      r_wb_pc   <= 1'b0;
`endif
    end else begin
      r_wb_pend <= (r_state == XFER) && w_is_load && w_valid && !flush;
      r_wb_reg  <= map_reg(w_k, 1'b1);
`ifdef POP_PC_BRANCH_EN
      r_wb_pc   <= (r_cls == CLS_POP) && (map_reg(w_k, 1'b1) == PC);
`endif
    end
  end

  // Next-state logic and the per-state memory/completion outputs.
  always_comb begin
    w_next       = r_state;
    busy         = 1'b0;
    mem_write_en = 1'b0;
    mem_addr     = '0;
    rf_read_addr = '0;
    mem_data_in  = '0;
    done         = 1'b0;
    base_wb_en   = 1'b0;
    base_wb_reg  = '0;
    base_wb_data = '0;
    case (r_state)
      IDLE: begin
        if (start) w_next = (w_list_in == '0) ? FIN : XFER;
      end
      XFER: begin
        busy     = 1'b1;
        mem_addr = r_addr;
        if (!w_is_load && w_valid) begin
          mem_write_en = 1'b1;
          rf_read_addr = map_reg(w_k, 1'b0);
          mem_data_in  = rf_read_data;
        end
        if (flush)       w_next = IDLE;
        else if (w_last) w_next = w_is_load ? LWB : FIN;
      end
      LWB: begin
        busy   = 1'b1;
        w_next = flush ? IDLE : FIN;
      end
      FIN: begin
        busy         = 1'b1;
        w_next       = IDLE;
        base_wb_reg  = r_base_reg;
        base_wb_data = r_base_new;
        if (!flush) begin
          done       = 1'b1;
          base_wb_en = r_base_ok;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Writeback port; a POP into PC is redirected to the branch port if enabled.
  always_comb begin
    wb_reg  = r_wb_pend ? r_wb_reg : '0;
    wb_data = r_wb_pend ? mem_data_out : '0;
`ifdef POP_PC_BRANCH_EN
    wb_en     = r_wb_pend && !r_wb_pc;
    pc_load   = r_wb_pend && r_wb_pc;
    pc_target = (r_wb_pend && r_wb_pc) ? (mem_data_out & ~32'h1) : '0;
`else
    wb_en     = r_wb_pend;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_ldm_stm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ldm_stm_sequencer
// Brief    : Directed self-checking bench for ldm_stm_sequencer with a small
//            register file and a registered-read data memory model.
//            Optional macro POP_PC_BRANCH_EN selects the PC-branch checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [6:0]  opCode = '0;
  logic [2:0]  base_reg = '0;
  logic [8:0]  reg_list = '0;
  logic [31:0] base_addr = '0;
  logic [3:0]  rf_read_addr;
  logic [31:0] rf_read_data;
  logic        mem_write_en;
  logic [6:0]  mem_opCode;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        wb_en;
  logic [3:0]  wb_reg;
  logic [31:0] wb_data;
  logic        base_wb_en;
  logic [3:0]  base_wb_reg;
  logic [31:0] base_wb_data;
  logic        busy;
  logic        done;
`ifdef POP_PC_BRANCH_EN
  logic        pc_load;
  logic [31:0] pc_target;
`endif

  logic [31:0] rf  [0:15];
  logic [31:0] mem [0:255];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rf_read_data = rf[rf_read_addr];

  // Data memory with registered read, as seen by the sequencer.
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr[9:2]] <= mem_data_in;
    mem_data_out <= mem[mem_addr[9:2]];
  end

  ldm_stm_sequencer #(.ADDR_STEP(4), .NREGS(9)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .flush        (flush),
    .opCode       (opCode),
    .base_reg     (base_reg),
    .reg_list     (reg_list),
    .base_addr    (base_addr),
    .rf_read_addr (rf_read_addr),
    .rf_read_data (rf_read_data),
    .mem_write_en (mem_write_en),
    .mem_opCode   (mem_opCode),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .wb_en        (wb_en),
    .wb_reg       (wb_reg),
    .wb_data      (wb_data),
    .base_wb_en   (base_wb_en),
    .base_wb_reg  (base_wb_reg),
    .base_wb_data (base_wb_data),
    .busy         (busy),
`ifdef POP_PC_BRANCH_EN
    .pc_load      (pc_load),
    .pc_target    (pc_target),
`endif
    .done         (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [6:0] op, input logic [2:0] rn,
                        input logic [8:0] lst, input logic [31:0] base);
    opCode    = op;
    base_reg  = rn;
    reg_list  = lst;
    base_addr = base;
    start     = 1'b1;
    cyc();
    start     = 1'b0;
  endtask

  function automatic logic [31:0] mrd(input logic [31:0] a);
    return mem[a[9:2]];
  endfunction

  initial begin
    for (int i = 0; i < 16; i++)  rf[i]  = 32'h1000 + i;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rf[0] = 32'hA; rf[2] = 32'hB; rf[14] = 32'hC;

    // Reset state
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_we", mem_write_en, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // PUSH {r0,r2,LR}, SP=0x100
    launch(7'b1011010, 3'd0, 9'b1_0000_0101, 32'h100);          // now cycle 2
    chk("push_busy", busy, 1);
    chk("push_we0", mem_write_en, 1);
    chk("push_a0", mem_addr, 32'hF4);
    chk("push_rf0", rf_read_addr, 0);
    chk("push_d0", mem_data_in, 32'hA);
    chk("push_opc", mem_opCode, 7'b1011010);
    cyc();                                                      // cycle 3
    chk("push_a1", mem_addr, 32'hF8);
    chk("push_d1", mem_data_in, 32'hB);
    chk("push_done_early", done, 0);
    cyc();                                                      // cycle 4
    chk("push_a2", mem_addr, 32'hFC);
    chk("push_rf2", rf_read_addr, 14);
    chk("push_d2", mem_data_in, 32'hC);
    cyc();                                                      // cycle 5
    chk("push_we_fin", mem_write_en, 0);
    chk("push_done", done, 1);
    chk("push_bwen", base_wb_en, 1);
    chk("push_bwreg", base_wb_reg, 13);
    chk("push_bwdata", base_wb_data, 32'hF4);
    cyc();                                                      // cycle 6
    chk("push_idle_busy", busy, 0);
    chk("push_idle_done", done, 0);
    chk("push_mem0", mrd(32'hF4), 32'hA);
    chk("push_mem1", mrd(32'hF8), 32'hB);
    chk("push_mem2", mrd(32'hFC), 32'hC);

    // POP {r1,r3} from SP=0xF4
    mem[8'h3D] = 32'h11; mem[8'h3E] = 32'h22;
    launch(7'b1011110, 3'd0, 9'b0_0000_1010, 32'hF4);           // cycle 2
    chk("pop_a0", mem_addr, 32'hF4);
    chk("pop_we", mem_write_en, 0);
    chk("pop_wb_early", wb_en, 0);
    cyc();                                                      // cycle 3
    chk("pop_a1", mem_addr, 32'hF8);
    chk("pop_wb0_en", wb_en, 1);
    chk("pop_wb0_reg", wb_reg, 1);
    chk("pop_wb0_data", wb_data, 32'h11);
    cyc();                                                      // cycle 4 (LWB)
    chk("pop_wb1_en", wb_en, 1);
    chk("pop_wb1_reg", wb_reg, 3);
    chk("pop_wb1_data", wb_data, 32'h22);
    chk("pop_lwb_busy", busy, 1);
    chk("pop_lwb_done", done, 0);
    cyc();                                                      // cycle 5
    chk("pop_done", done, 1);
    chk("pop_wb_off", wb_en, 0);
    chk("pop_bwen", base_wb_en, 1);
    chk("pop_bwreg", base_wb_reg, 13);
    chk("pop_bwdata", base_wb_data, 32'hFC);
    cyc();

    // LDM r2!,{r2,r5}, base 0x40
    mem[8'h10] = 32'h1234; mem[8'h11] = 32'h5678;
    launch(7'b1100101, 3'd2, 9'b0_0010_0100, 32'h40);           // cycle 2
    chk("ldm_a0", mem_addr, 32'h40);
    cyc();                                                      // cycle 3
    chk("ldm_wb0_reg", wb_reg, 2);
    chk("ldm_wb0_data", wb_data, 32'h1234);
    cyc();                                                      // cycle 4
    chk("ldm_wb1_reg", wb_reg, 5);
    chk("ldm_wb1_data", wb_data, 32'h5678);
    cyc();                                                      // cycle 5
    chk("ldm_done", done, 1);
    chk("ldm_bwen", base_wb_en, 0);
    cyc();

    // Empty-list STM r3
    launch(7'b1100001, 3'd3, 9'h000, 32'h80);                   // cycle 2
    chk("emp_we", mem_write_en, 0);
    chk("emp_done", done, 1);
    chk("emp_bwen", base_wb_en, 1);
    chk("emp_bwreg", base_wb_reg, 3);
    chk("emp_bwdata", base_wb_data, 32'h80);
    cyc();

    // Unrecognised opcode behaves as empty, no base writeback
    launch(7'b0000000, 3'd0, 9'h003, 32'h90);                   // cycle 2
    chk("bad_we", mem_write_en, 0);
    chk("bad_done", done, 1);
    chk("bad_bwen", base_wb_en, 0);
    cyc();

    // Flush on the 2nd cycle of a 4-register LDM
    mem[8'h18] = 32'h61; mem[8'h19] = 32'h62; mem[8'h1A] = 32'h63; mem[8'h1B] = 32'h64;
    launch(7'b1100100, 3'd0, 9'b0_0001_1110, 32'h60);           // cycle 2
    chk("fl_a0", mem_addr, 32'h60);
    cyc();                                                      // cycle 3
    flush = 1'b1;
    #1;
    chk("fl_wb0_en", wb_en, 1);
    chk("fl_wb0_reg", wb_reg, 1);
    chk("fl_wb0_data", wb_data, 32'h61);
    chk("fl_done", done, 0);
    cyc();                                                      // cycle 4
    flush = 1'b0;
    chk("fl_busy", busy, 0);
    chk("fl_wb_supp", wb_en, 0);
    chk("fl_done2", done, 0);
    launch(7'b1100000, 3'd1, 9'b0_0000_0001, 32'h20);           // STM r1!,{r0}
    chk("fl_restart_busy", busy, 1);
    chk("fl_restart_we", mem_write_en, 1);
    chk("fl_restart_addr", mem_addr, 32'h20);
    chk("fl_restart_data", mem_data_in, 32'hA);
    cyc();
    chk("fl_restart_done", done, 1);
    chk("fl_restart_bw", base_wb_data, 32'h24);
    cyc();

    // Asynchronous reset in the middle of a PUSH
    launch(7'b1011010, 3'd0, 9'b1_0000_0101, 32'h100);          // cycle 2
    cyc();                                                      // cycle 3
    rst_n = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_we", mem_write_en, 0);
    chk("ar_addr", mem_addr, 0);
    chk("ar_data", mem_data_in, 0);
    chk("ar_opc", mem_opCode, 0);
    #1;
    rst_n = 1'b1;
    cyc();
    chk("ar_idle", busy, 0);
    chk("ar_no_done", done, 0);
    launch(7'b1011010, 3'd0, 9'b0_0000_0001, 32'h200);          // PUSH {r0}
    chk("ar_push_addr", mem_addr, 32'h1FC);
    chk("ar_push_data", mem_data_in, 32'hA);
    cyc();                                                      // cycle 3 = N+2
    chk("ar_push_done", done, 1);
    chk("ar_push_bw", base_wb_data, 32'h1FC);
    cyc();

    // POP {PC} of 0x201 from 0x300
    mem[8'hC0] = 32'h201;
    launch(7'b1011110, 3'd0, 9'h100, 32'h300);                  // cycle 2
    chk("pc_addr", mem_addr, 32'h300);
    cyc();                                                      // cycle 3 (LWB)
`ifdef POP_PC_BRANCH_EN
    chk("pc_load", pc_load, 1);
    chk("pc_target", pc_target, 32'h200);
    chk("pc_wb_off", wb_en, 0);
`else
    chk("pc_wb_en", wb_en, 1);
    chk("pc_wb_reg", wb_reg, 15);
    chk("pc_wb_data", wb_data, 32'h201);
`endif
    cyc();                                                      // cycle 4
    chk("pc_done", done, 1);
    chk("pc_bw", base_wb_data, 32'h304);
`ifdef POP_PC_BRANCH_EN
    chk("pc_load_off", pc_load, 0);
`endif
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
